// File: rtl/cmd_pkg.sv
// Shared types and widths for the command entry controller.
package cmd_pkg;

  localparam int ADDR_W = 5;
  localparam int CMD_W  = 7;
  localparam int WORD_W = 12;

  // Entry sequence: edit address, edit command, offer word downstream.
  typedef enum logic [1:0] {
    ADDR = 2'd0,
    CMD  = 2'd1,
    SEND = 2'd2
  } entry_state_t;

endpackage

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, and a
// single-cycle pulse on each accepted 0->1 transition of the stable level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The new level is accepted on its DEBOUNCE_CYCLES-th consecutive sample.
  assign accept = (sync_2 != stable) && (cnt == CNT_LAST);

  // Two-stage synchronizer for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // Stability counter: any sample matching the stable level restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_2 == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= sync_2;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // One pulse per accepted press; a held button never re-triggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pulse <= 1'b0;
    else        pulse <= accept && sync_2;
  end

endmodule

// File: rtl/command_entry_ctrl.sv
// Operator entry of a {address, command} word from slide switches and two
// buttons, with a valid/ready hand-off to the command processor.
// Optional build macro: CMD_ENTRY_BLINK_EN blinks the field being edited.
//
// Handshake: cmd_valid is high exactly in SEND; a transfer happens on a
// clock edge where cmd_valid && cmd_ready. While cmd_valid is high cmd_buf
// is frozen and cmd_valid only drops after a transfer (or on reset).
module command_entry_ctrl
  import cmd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CMD_W-1:0]  sw,
  input  logic              btn_ok,
  input  logic              btn_back,
  output logic [WORD_W-1:0] cmd_buf,
  output logic [3:0]        blank,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              editing_addr,
  output logic [7:0]        cmd_count
);

  entry_state_t      state;
  entry_state_t      state_nxt;
  logic [CMD_W-1:0]  sw_s1;
  logic [CMD_W-1:0]  sw_s2;
  logic [ADDR_W-1:0] addr_lat;
  logic [CMD_W-1:0]  cmd_lat;
  logic              ok_pulse;
  logic              back_pulse;
  logic              xfer;

  assign xfer = (state == SEND) && cmd_ready;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ok (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_ok),
    .pulse (ok_pulse)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_back (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_back),
    .pulse (back_pulse)
  );

  // Two-stage synchronizer for the slide switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ADDR;
    else        state <= state_nxt;
  end

  // Next-state logic; ok takes priority over back when both pulse together.
  always_comb begin
    state_nxt = state;
    case (state)
      ADDR: if (ok_pulse) state_nxt = CMD;
      CMD: begin
        if (ok_pulse)        state_nxt = SEND;
        else if (back_pulse) state_nxt = ADDR;
      end
      SEND: if (xfer) state_nxt = ADDR;
      default: state_nxt = ADDR;
    endcase
  end

  // Field latches, display word register and transfer counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lat  <= '0;
      cmd_lat   <= '0;
      cmd_buf   <= '0;
      cmd_count <= '0;
    end else begin
      case (state)
        ADDR: begin
          cmd_buf <= {sw_s2[ADDR_W-1:0], cmd_lat};
          if (ok_pulse) addr_lat <= sw_s2[ADDR_W-1:0];
        end
        CMD: begin
          cmd_buf <= {addr_lat, sw_s2};
          if (ok_pulse) cmd_lat <= sw_s2;
        end
        SEND: begin
          cmd_buf <= {addr_lat, cmd_lat};
          if (xfer) cmd_count <= cmd_count + 8'd1;
        end
        default: cmd_buf <= {addr_lat, cmd_lat};
      endcase
    end
  end

`ifdef CMD_ENTRY_BLINK_EN
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_CYCLES - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               phase;

  // Blink timer; restarts on every state change so the new field shows at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (state_nxt != state) begin
      blink_cnt <= '0;
      phase     <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end
`else
  logic unused_blink;
  assign unused_blink = (BLINK_CYCLES > 0);
`endif

  // Outputs decoded from the current state.
  always_comb begin
    cmd_valid    = (state == SEND);
    editing_addr = (state == ADDR);
    blank        = 4'b0000;
`ifdef CMD_ENTRY_BLINK_EN
    case (state)
      ADDR:    blank = {2'b00, phase, phase};
      CMD:     blank = {phase, phase, 2'b00};
      default: blank = 4'b0000;
    endcase
`endif
  end

endmodule

// File: tb/tb_command_entry_ctrl.sv
// Directed bench for command_entry_ctrl with a transfer scoreboard.
module tb_command_entry_ctrl;

  logic        clk;
  logic        rst_n;
  logic [6:0]  sw;
  logic        btn_ok;
  logic        btn_back;
  logic [11:0] cmd_buf;
  logic [3:0]  blank;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        editing_addr;
  logic [7:0]  cmd_count;

  logic [11:0] exp_q[$];
  int          total = 0;
  int          bad = 0;

  command_entry_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_ok       (btn_ok),
    .btn_back     (btn_back),
    .cmd_buf      (cmd_buf),
    .blank        (blank),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .editing_addr (editing_addr),
    .cmd_count    (cmd_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: while the word is offered it must equal the head of exp_q.
  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: cmd_buf=%h with no expected word", cmd_buf);
      end else begin
        if (cmd_buf !== exp_q[0]) begin
          bad++;
          $display("FAIL send_word: got %h want %h", cmd_buf, exp_q[0]);
        end
        if (cmd_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance n clocks, leaving inputs to change 1ns after the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press (and release) the selected buttons long enough to debounce.
  task automatic press(input logic ok, input logic back);
    btn_ok   = ok;
    btn_back = back;
    cyc(10);
    btn_ok   = 1'b0;
    btn_back = 1'b0;
    cyc(10);
  endtask

  task automatic transfer();
    cmd_ready = 1'b1;
    cyc(1);
    cmd_ready = 1'b0;
  endtask

  // Wait on negedges until editing_addr reaches val; bounded.
  task automatic wait_edit(input logic val);
    int n = 0;
    while (editing_addr !== val && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (editing_addr !== val) begin
      bad++;
      $display("FAIL wait_edit: editing_addr=%b want %b after %0d cycles", editing_addr, val, n);
    end
  endtask

  // From the first cycle in a new state, blank is 0 for 8 samples, then pat.
  task automatic check_blink(input string name, input logic [3:0] pat);
    check({name, "_0"}, {8'h0, blank}, 12'h0);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
`ifdef CMD_ENTRY_BLINK_EN
      if (i == 8) check({name, "_8"}, {8'h0, blank}, {8'h0, pat});
      else if (i == 4) check({name, "_4"}, {8'h0, blank}, 12'h0);
`else
      if (i == 8) check({name, "_8"}, {8'h0, blank}, {8'h0, pat & 4'b0000});
`endif
    end
  endtask

  initial begin
    rst_n = 1'b0; sw = '0; btn_ok = 1'b0; btn_back = 1'b0; cmd_ready = 1'b0;
    cyc(3);
    check("rst_cmd_buf", cmd_buf, 12'h000);
    check("rst_valid", {11'h0, cmd_valid}, 12'h0);
    check("rst_edit", {11'h0, editing_addr}, 12'h1);
    check("rst_count", {4'h0, cmd_count}, 12'h0);
    check("rst_blank", {8'h0, blank}, 12'h0);
    rst_n = 1'b1;
    cyc(2);

    // Basic entry and held-off transfer
    sw = 7'h13;
    press(1'b1, 1'b0);
    check("to_cmd_edit", {11'h0, editing_addr}, 12'h0);
    sw = 7'h5A;
    exp_q.push_back(12'h9DA);
    press(1'b1, 1'b0);
    check("send_valid", {11'h0, cmd_valid}, 12'h1);
    for (int i = 0; i < 20; i++) begin
      sw       = 7'(i * 7);
      btn_ok   = i[1];
      btn_back = i[2];
      cyc(1);
    end
    btn_ok = 1'b0; btn_back = 1'b0;
    cyc(12);
    check("hold_valid", {11'h0, cmd_valid}, 12'h1);
    transfer();
    check("xfer_valid", {11'h0, cmd_valid}, 12'h0);
    check("xfer_count", {4'h0, cmd_count}, 12'h001);
    check("xfer_edit", {11'h0, editing_addr}, 12'h1);

    // Switch-to-display latency; sw[6:5] ignored in ADDR
    sw = 7'h00;
    cyc(5);
    check("lat_base", cmd_buf, 12'h05A);
    sw = 7'h6A;
    cyc(2);
    check("lat_2clk", cmd_buf, 12'h05A);
    cyc(1);
    check("lat_3clk", cmd_buf, 12'h55A);

    // Bounce then long hold: exactly one advance
    btn_ok = 1'b1; cyc(2);
    btn_ok = 1'b0; cyc(2);
    btn_ok = 1'b1; cyc(2);
    cyc(10);
    check("bounce_edit", {11'h0, editing_addr}, 12'h0);
    check("bounce_valid", {11'h0, cmd_valid}, 12'h0);
    cyc(100);
    check("hold_valid0", {11'h0, cmd_valid}, 12'h0);
    check("hold_edit", {11'h0, editing_addr}, 12'h0);
    btn_ok = 1'b0;
    cyc(10);

    // ok and back together in CMD: ok wins
    sw = 7'h21;
    exp_q.push_back(12'h521);
    press(1'b1, 1'b1);
    check("both_valid", {11'h0, cmd_valid}, 12'h1);
    transfer();
    check("both_count", {4'h0, cmd_count}, 12'h002);

    // back from CMD keeps the latched command
    sw = 7'h03;
    press(1'b1, 1'b0);
    check("cmd2_edit", {11'h0, editing_addr}, 12'h0);
    sw = 7'h44;
    cyc(5);
    check("cmd2_track", cmd_buf, 12'h1C4);
    press(1'b0, 1'b1);
    check("back_edit", {11'h0, editing_addr}, 12'h1);
    check("back_buf", cmd_buf, 12'h221);

    // Asynchronous reset in SEND
    press(1'b1, 1'b0);
    sw = 7'h11;
    exp_q.push_back(12'h211);
    press(1'b1, 1'b0);
    check("pre_rst_valid", {11'h0, cmd_valid}, 12'h1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_valid", {11'h0, cmd_valid}, 12'h0);
    check("arst_edit", {11'h0, editing_addr}, 12'h1);
    check("arst_count", {4'h0, cmd_count}, 12'h0);
    check("arst_buf", cmd_buf, 12'h000);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(2);

    // Blink of the active field
    btn_ok = 1'b1;
    wait_edit(1'b0);
    check_blink("blink_cmd", 4'b1100);
    btn_ok = 1'b0;
    cyc(10);
    btn_back = 1'b1;
    wait_edit(1'b1);
    check_blink("blink_addr", 4'b0011);
    btn_back = 1'b0;
    cyc(10);
    check("final_queue", 12'(exp_q.size()), 12'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded limit");
    $fatal(1);
  end

endmodule
